// File: rtl/alu_shift_sequencer.sv
// Multi-cycle sequencer that drives the ALU's FunSel/WF pins to build N-bit shifts/rotates from single-bit steps.
// Optional feature: define FLAGS_LAST_ONLY_EN to limit flag writes of non-circular shifts to the final step.
module alu_shift_sequencer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             Width,
    input  logic [CNT_W-1:0] Count,
    output logic [4:0]       FunSel,
    output logic             WF,
    output logic             AccLoad,
    output logic             AccSel,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             width_q, width_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             illegal_q, illegal_d;

    logic [4:0] fun_sel_d;
    logic       wf_d, acc_load_d, acc_sel_d, busy_d, done_d, err_d;
    logic [3:0] shift_code;

    // Next state plus the outputs that belong to that next state, so every output leaves a flop.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        width_d    = width_q;
        rem_d      = rem_q;
        illegal_d  = illegal_q;
        fun_sel_d  = 5'b00000;
        wf_d       = 1'b0;
        acc_load_d = 1'b0;
        acc_sel_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        shift_code = 4'b0000;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d      = Op;
                    width_d   = Width;
                    rem_d     = Count;
                    illegal_d = (Op > OP_W'(4));
                    state_d   = (Op > OP_W'(4)) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_d = (rem_q == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_q >= CNT_W'(1)) begin
                    rem_d = rem_q - CNT_W'(1);
                end
                if (rem_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (op_d)
            3'd0:    shift_code = 4'b1011;
            3'd1:    shift_code = 4'b1100;
            3'd2:    shift_code = 4'b1101;
            3'd3:    shift_code = 4'b1110;
            3'd4:    shift_code = 4'b1111;
            default: shift_code = 4'b0000;
        endcase

        case (state_d)
            LOAD: begin
                acc_load_d = 1'b1;
                fun_sel_d  = {width_d, 4'b0000};
                busy_d     = 1'b1;
            end
            SHIFT: begin
                acc_load_d = 1'b1;
                acc_sel_d  = 1'b1;
                fun_sel_d  = {width_d, shift_code};
                busy_d     = 1'b1;
`ifdef FLAGS_LAST_ONLY_EN
                // Rotates chain through C, so they must write flags on every step.
                wf_d = (op_d == OP_W'(3)) || (op_d == OP_W'(4)) || (rem_d == CNT_W'(1));
`else
                wf_d = 1'b1;
`endif
            end
            DONE: begin
                done_d = 1'b1;
                err_d  = illegal_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            width_q   <= 1'b0;
            rem_q     <= '0;
            illegal_q <= 1'b0;
            FunSel    <= 5'b00000;
            WF        <= 1'b0;
            AccLoad   <= 1'b0;
            AccSel    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            width_q   <= width_d;
            rem_q     <= rem_d;
            illegal_q <= illegal_d;
            FunSel    <= fun_sel_d;
            WF        <= wf_d;
            AccLoad   <= acc_load_d;
            AccSel    <= acc_sel_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Err       <= err_d;
        end
    end

endmodule
